iob_split: RTL and testbench

IOB_SPLIT -- requirements
Module: iob_split

---
 rtl/iob_split_pkg.sv | 24 ++
 rtl/iob_reg_re.sv | 44 ++++
 rtl/iob_split.sv | 164 ++++++++++++++++
 tb/tb_iob_split.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_split_pkg.sv
// iob_split_pkg -- constants and helpers shared by the IOb split block.
//
// Contents:
//   sel_w_f      width of the slave select field taken from the top address bits
//   PEND_CNT_W   width of the outstanding-read counter
//   ERR_RDATA    read data returned for unmapped selects (sliced to DATA_W)
//
// Configuration macro: IOB_SPLIT_DECERR_EN widens the select by one bit so that
// out-of-range selects can be routed to the internal error responder.
package iob_split_pkg;

  localparam int PEND_CNT_W      = 4;
  localparam int ERR_RDATA_MAX_W = 64;
  localparam logic [ERR_RDATA_MAX_W-1:0] ERR_RDATA = '1;

  function automatic int sel_w_f(input int n_slaves);
`ifdef IOB_SPLIT_DECERR_EN
    return $clog2(n_slaves) + 1;
`else
    return $clog2(n_slaves);
`endif
  endfunction

endpackage

// File: rtl/iob_reg_re.sv
// iob_reg_re -- register with asynchronous reset, synchronous reset and enable.
//
// Ports:
//   clk_i   clock
//   arst_i  asynchronous active-high reset (loads RST_VAL)
//   rst_i   synchronous active-high reset (loads RST_VAL)
//   en_i    load enable
//   data_i  next value
//   data_o  registered value
module iob_reg_re #(
  parameter int                DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (rst_i) begin
      data_d = RST_VAL;
    end else if (en_i) begin
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_q <= RST_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/iob_split.sv
// iob_split -- routes one upstream IOb request port to N_SLAVES downstream IOb
// ports, selected by the top address bits, and tracks outstanding reads so
// that responses come back in order from a single slave.
//
// Ports:
//   clk_i, arst_i               clock, asynchronous active-high reset
//   m_avalid_i .. m_wstrb_i     upstream request (write when any strobe set)
//   m_rvalid_o, m_rdata_o       upstream read response
//   m_ready_o                   upstream accept
//   s_avalid_o                  one-hot downstream request valid
//   s_addr_o/s_wdata_o/s_wstrb_o shared downstream request fields
//   s_rvalid_i, s_rdata_i       per-slave read responses (packed)
//   s_ready_i                   per-slave accept
//
// Configuration macro: IOB_SPLIT_DECERR_EN -- when defined, selects at or above
// N_SLAVES are served by an internal responder (always ready, all-ones data one
// cycle after accept). When undefined, such selects are never accepted.
module iob_split
  import iob_split_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int N_SLAVES    = 4,
  parameter int MAX_PENDING = 4
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic                         m_avalid_i,
  input  logic [ADDR_W-1:0]            m_addr_i,
  input  logic [DATA_W-1:0]            m_wdata_i,
  input  logic [DATA_W/8-1:0]          m_wstrb_i,
  output logic                         m_rvalid_o,
  output logic [DATA_W-1:0]            m_rdata_o,
  output logic                         m_ready_o,
  output logic [N_SLAVES-1:0]          s_avalid_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [DATA_W-1:0]            s_wdata_o,
  output logic [DATA_W/8-1:0]          s_wstrb_o,
  input  logic [N_SLAVES-1:0]          s_rvalid_i,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata_i,
  input  logic [N_SLAVES-1:0]          s_ready_i
);

  localparam int SEL_W = sel_w_f(N_SLAVES);

  logic [SEL_W-1:0]      sel;
  logic [SEL_W-1:0]      idx;
  logic [SEL_W-1:0]      pend_sel;
  logic                  is_read;
  logic                  stall;
  logic                  ready_sel;
  logic                  rvalid_sel;
  logic [DATA_W-1:0]     rdata_sel;
  logic                  acc_rd;
  logic                  resp;
  logic [PEND_CNT_W-1:0] pend_cnt_d;
  logic [PEND_CNT_W-1:0] pend_cnt_q;

  assign sel     = m_addr_i[ADDR_W-1 -: SEL_W];
  assign is_read = ~|m_wstrb_i;

`ifdef IOB_SPLIT_DECERR_EN
  logic err_rvalid;
  // Every unmapped select collapses onto the responder index N_SLAVES, so two
  // different unmapped selects count as the same target for ordering.
  assign idx = (int'(sel) >= N_SLAVES) ? SEL_W'(N_SLAVES) : sel;
`else
  assign idx = sel;
`endif

  // Ordering: only one target may have reads outstanding at a time.
  assign stall = ((pend_cnt_q != '0) && (idx != pend_sel)) ||
                 (is_read && (pend_cnt_q == PEND_CNT_W'(MAX_PENDING)));

  // Request-side mux; an unmapped select without the responder stays not-ready.
  always_comb begin
    ready_sel = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      s_avalid_o[i] = (idx == SEL_W'(i)) & m_avalid_i & ~stall;
      if (idx == SEL_W'(i)) begin
        ready_sel = s_ready_i[i];
      end
    end
`ifdef IOB_SPLIT_DECERR_EN
    if (idx == SEL_W'(N_SLAVES)) begin
      ready_sel = 1'b1;
    end
`endif
  end

  // Response-side mux follows pend_sel. The default data is the error pattern,
  // which is also what the responder returns; mapped slaves override it.
  always_comb begin
    rvalid_sel = 1'b0;
    rdata_sel  = ERR_RDATA[DATA_W-1:0];
    for (int i = 0; i < N_SLAVES; i++) begin
      if (pend_sel == SEL_W'(i)) begin
        rvalid_sel = s_rvalid_i[i];
        rdata_sel  = s_rdata_i[i*DATA_W +: DATA_W];
      end
    end
`ifdef IOB_SPLIT_DECERR_EN
    if (pend_sel == SEL_W'(N_SLAVES)) begin
      rvalid_sel = err_rvalid;
    end
`endif
  end

  assign m_ready_o  = ready_sel & ~stall;
  assign m_rvalid_o = rvalid_sel & (pend_cnt_q != '0);
  assign m_rdata_o  = rdata_sel;
  assign s_addr_o   = m_addr_i;
  assign s_wdata_o  = m_wdata_i;
  assign s_wstrb_o  = m_wstrb_i;

  assign acc_rd = m_avalid_i & m_ready_o & is_read;
  assign resp   = m_rvalid_o;

  // The counter cannot wrap: accepts stop at MAX_PENDING and responses are
  // only counted while pend_cnt_q is non-zero.
  always_comb begin
    pend_cnt_d = pend_cnt_q;
    if (acc_rd && !resp) begin
      pend_cnt_d = pend_cnt_q + PEND_CNT_W'(1);
    end else if (!acc_rd && resp) begin
      pend_cnt_d = pend_cnt_q - PEND_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      pend_cnt_q <= '0;
    end else begin
      pend_cnt_q <= pend_cnt_d;
    end
  end

  iob_reg_re #(
    .DATA_W  (SEL_W),
    .RST_VAL ('0)
  ) u_pend_sel (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .rst_i  (1'b0),
    .en_i   (acc_rd),
    .data_i (idx),
    .data_o (pend_sel)
  );

`ifdef IOB_SPLIT_DECERR_EN
  iob_reg_re #(
    .DATA_W  (1),
    .RST_VAL (1'b0)
  ) u_err_rvalid (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .rst_i  (1'b0),
    .en_i   (1'b1),
    .data_i (acc_rd & (idx == SEL_W'(N_SLAVES))),
    .data_o (err_rvalid)
  );
`endif

endmodule

// File: tb/tb_iob_split.sv
// tb_iob_split -- directed bench for iob_split. Two instances: A uses default
// parameters, B uses N_SLAVES=3 and MAX_PENDING=2. A reference model checks
// both every cycle; directed literal checks pin the key scenarios.
// Honours IOB_SPLIT_DECERR_EN the same way as the design.
module tb_iob_split;

`ifdef IOB_SPLIT_DECERR_EN
  localparam int SELW_TB = 3;
  localparam bit DECERR  = 1'b1;
`else
  localparam int SELW_TB = 2;
  localparam bit DECERR  = 1'b0;
`endif

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  // Instance A signals
  logic        a_av;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_wstrb;
  logic        a_mrv, a_mrdy;
  logic [31:0] a_mrd;
  logic [3:0]  a_sav;
  logic [31:0] a_saddr, a_swdata;
  logic [3:0]  a_swstrb;
  logic [3:0]  a_srv, a_srdy;
  logic [127:0] a_srd;

  // Instance B signals
  logic        b_av;
  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_wstrb;
  logic        b_mrv, b_mrdy;
  logic [31:0] b_mrd;
  logic [2:0]  b_sav;
  logic [31:0] b_saddr, b_swdata;
  logic [3:0]  b_swstrb;
  logic [2:0]  b_srv, b_srdy;
  logic [95:0] b_srd;

  iob_split u_a (
    .clk_i(clk), .arst_i(arst),
    .m_avalid_i(a_av), .m_addr_i(a_addr), .m_wdata_i(a_wdata), .m_wstrb_i(a_wstrb),
    .m_rvalid_o(a_mrv), .m_rdata_o(a_mrd), .m_ready_o(a_mrdy),
    .s_avalid_o(a_sav), .s_addr_o(a_saddr), .s_wdata_o(a_swdata), .s_wstrb_o(a_swstrb),
    .s_rvalid_i(a_srv), .s_rdata_i(a_srd), .s_ready_i(a_srdy)
  );

  iob_split #(.N_SLAVES(3), .MAX_PENDING(2)) u_b (
    .clk_i(clk), .arst_i(arst),
    .m_avalid_i(b_av), .m_addr_i(b_addr), .m_wdata_i(b_wdata), .m_wstrb_i(b_wstrb),
    .m_rvalid_o(b_mrv), .m_rdata_o(b_mrd), .m_ready_o(b_mrdy),
    .s_avalid_o(b_sav), .s_addr_o(b_saddr), .s_wdata_o(b_swdata), .s_wstrb_o(b_swstrb),
    .s_rvalid_i(b_srv), .s_rdata_i(b_srd), .s_ready_i(b_srdy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_addr(input int sel, input logic [31:0] low);
    logic [31:0] s;
    s = 32'(sel);
    return (s << (32 - SELW_TB)) | low;
  endfunction

  // Reference model state: outstanding read count, their target, responder pulse.
  int m_cnt [2];
  int m_psel[2];
  bit m_errv[2];

  task automatic model_step(
    input int k, input string nm, input int nsl, input int maxp, input logic rst_now,
    input logic av, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
    input logic [3:0] rdy, input logic [3:0] rv, input logic [127:0] rd,
    input logic [3:0] d_sav, input logic d_mrdy, input logic d_mrv, input logic [31:0] d_mrd,
    input logic [31:0] d_saddr, input logic [31:0] d_swdata, input logic [3:0] d_swstrb,
    input logic [3:0] d_pcnt);
    int sel, idx;
    bit mapped, err, rdq, stall, e_mrdy, src, e_rv, acc;
    logic [3:0]  e_sav;
    logic [31:0] e_rd;
    sel    = int'(addr >> (32 - SELW_TB));
    mapped = sel < nsl;
    err    = !mapped && DECERR;
    idx    = mapped ? sel : nsl;
    rdq    = (wstrb == 4'h0);
    if (rst_now) begin
      m_cnt[k] = 0; m_psel[k] = 0; m_errv[k] = 1'b0;
    end
    stall  = (m_cnt[k] != 0 && idx != m_psel[k]) || (rdq && m_cnt[k] == maxp);
    e_mrdy = (mapped ? rdy[sel] : err) && !stall;
    e_sav  = 4'h0;
    if (mapped && av && !stall) e_sav[sel] = 1'b1;
    src    = (m_psel[k] < nsl) ? rv[m_psel[k]] : m_errv[k];
    e_rv   = src && (m_cnt[k] != 0);
    e_rd   = (m_psel[k] < nsl) ? rd[m_psel[k]*32 +: 32] : 32'hFFFF_FFFF;
    check({nm, "_m_ready"},  64'(d_mrdy),   64'(e_mrdy));
    check({nm, "_s_avalid"}, 64'(d_sav),    64'(e_sav));
    check({nm, "_m_rvalid"}, 64'(d_mrv),    64'(e_rv));
    check({nm, "_m_rdata"},  64'(d_mrd),    64'(e_rd));
    check({nm, "_s_fields"}, {d_saddr, d_swdata ^ {28'h0, d_swstrb}},
                             {addr, wdata ^ {28'h0, wstrb}});
    check({nm, "_pend_cnt"}, 64'(d_pcnt),   64'(m_cnt[k]));
    if (!rst_now) begin
      acc = av && e_mrdy && rdq;
      m_cnt[k] = m_cnt[k] + int'(acc) - int'(e_rv);
      if (acc) m_psel[k] = idx;
      m_errv[k] = acc && err;
    end
  endtask

  always @(negedge clk) begin
    model_step(0, "A", 4, 4, arst, a_av, a_addr, a_wdata, a_wstrb, a_srdy, a_srv, a_srd,
               a_sav, a_mrdy, a_mrv, a_mrd, a_saddr, a_swdata, a_swstrb, u_a.pend_cnt_q);
    model_step(1, "B", 3, 2, arst, b_av, b_addr, b_wdata, b_wstrb, {1'b0, b_srdy},
               {1'b0, b_srv}, {32'h0, b_srd}, {1'b0, b_sav}, b_mrdy, b_mrv, b_mrd,
               b_saddr, b_swdata, b_swstrb, u_b.pend_cnt_q);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd_a(input int slot, input logic [31:0] val);
    for (int i = 0; i < 4; i++) a_srd[i*32 +: 32] = (i == slot) ? val : 32'hDEAD_0000 + 32'(i);
  endtask

  task automatic set_rd_b(input int slot, input logic [31:0] val);
    for (int i = 0; i < 3; i++) b_srd[i*32 +: 32] = (i == slot) ? val : 32'hBEEF_0000 + 32'(i);
  endtask

  task automatic a_idle();
    a_av = 1'b0; a_addr = 32'h0; a_wdata = 32'h0; a_wstrb = 4'h0;
    a_srdy = 4'hF; a_srv = 4'h0;
  endtask

  task automatic b_idle();
    b_av = 1'b0; b_addr = 32'h0; b_wdata = 32'h0; b_wstrb = 4'h0;
    b_srdy = 3'h7; b_srv = 3'h0;
  endtask

  task automatic a_req(input int sel, input logic [3:0] wstrb);
    a_av = 1'b1; a_addr = mk_addr(sel, 32'h10 * 32'(sel)); a_wstrb = wstrb;
    a_wdata = 32'hA5A5_0000 | 32'(sel);
  endtask

  task automatic b_req(input int sel, input logic [3:0] wstrb);
    b_av = 1'b1; b_addr = mk_addr(sel, 32'h20); b_wstrb = wstrb;
    b_wdata = 32'h5A5A_0000 | 32'(sel);
  endtask

  initial begin
    arst = 1'b1;
    a_idle(); b_idle();
    set_rd_a(0, 32'hDEAD_0000); set_rd_b(0, 32'hBEEF_0000);
    cyc();
    check("rst_a_rvalid", 64'(a_mrv), 64'h0);
    check("rst_a_cnt", 64'(u_a.pend_cnt_q), 64'h0);
    cyc(); cyc();
    arst = 1'b0;
    cyc();
    check("post_rst_rvalid", 64'(a_mrv), 64'h0);

    // Write to slave 2, no read tracking
    a_av = 1'b1; a_addr = mk_addr(2, 32'h10); a_wdata = 32'h1234_5678;
    a_wstrb = 4'hF; a_srdy = 4'b0100; #1;
    check("wr_s_avalid", 64'(a_sav), 64'b0100);
    check("wr_m_ready", 64'(a_mrdy), 64'h1);
    cyc(); a_idle(); #1;
    check("wr_cnt", 64'(u_a.pend_cnt_q), 64'h0);

    // Three back-to-back reads to slave 1, answered two cycles later
    cyc(); a_req(1, 4'h0);
    cyc();
    cyc(); a_srv = 4'b0010; set_rd_a(1, 32'h11); #1;
    check("rd3_rv1", 64'(a_mrv), 64'h1);
    check("rd3_d1", 64'(a_mrd), 64'h11);
    cyc(); a_av = 1'b0; set_rd_a(1, 32'h22); #1;
    check("rd3_d2", 64'({a_mrv, a_mrd}), 64'h1_0000_0022);
    cyc(); set_rd_a(1, 32'h33); #1;
    check("rd3_d3", 64'({a_mrv, a_mrd}), 64'h1_0000_0033);
    cyc(); a_srv = 4'h0; #1;
    check("rd3_cnt0", 64'(u_a.pend_cnt_q), 64'h0);

    // Read to slave 0 pending blocks a read to slave 3
    cyc(); a_req(0, 4'h0);
    cyc(); a_req(3, 4'h0); #1;
    check("ord_rdy0", 64'(a_mrdy), 64'h0);
    check("ord_av0", 64'(a_sav), 64'h0);
    cyc();
    cyc(); a_srv = 4'b0001; set_rd_a(0, 32'h77); #1;
    check("ord_resp", 64'({a_mrv, a_mrdy}), 64'b10);
    cyc(); a_srv = 4'h0; #1;
    check("ord_acc", 64'({a_mrdy, a_sav}), 64'b1_1000);
    cyc(); a_av = 1'b0; a_srv = 4'b1000; set_rd_a(3, 32'h44); #1;
    check("ord_d3", 64'({a_mrv, a_mrd}), 64'h1_0000_0044);
    cyc(); a_srv = 4'h0;

    // Writes while a read to slave 1 is pending
    cyc(); a_req(1, 4'h0);
    cyc(); a_req(1, 4'h3); #1;
    check("wpend_same", 64'({a_mrdy, a_sav}), 64'b1_0010);
    cyc(); a_req(2, 4'h3); #1;
    check("wpend_other", 64'(a_mrdy), 64'h0);
    cyc(); a_av = 1'b0; a_srv = 4'b0100; #1;
    check("wrong_slave", 64'(a_mrv), 64'h0);
    cyc(); a_srv = 4'b0010; set_rd_a(1, 32'h55); #1;
    check("wpend_d", 64'({a_mrv, a_mrd}), 64'h1_0000_0055);
    cyc(); a_srv = 4'h0;

    // Slave not ready: request visible, not accepted
    cyc(); a_req(2, 4'h0); a_srdy = 4'b1011; #1;
    check("nrdy", 64'({a_mrdy, a_sav}), 64'b0_0100);
    cyc(); a_idle(); #1;
    check("nrdy_cnt", 64'(u_a.pend_cnt_q), 64'h0);

    // Spurious response, then reset with two reads in flight
    cyc(); a_srv = 4'b1000; #1;
    check("spurious", 64'(a_mrv), 64'h0);
    cyc(); a_srv = 4'h0; a_req(2, 4'h0);
    cyc();
    cyc(); a_av = 1'b0; arst = 1'b1; #1;
    check("arst_cnt", 64'(u_a.pend_cnt_q), 64'h0);
    cyc(); arst = 1'b0; a_srv = 4'b0100; #1;
    check("late_resp", 64'(a_mrv), 64'h0);
    cyc(); a_srv = 4'h0; #1;
    check("late_cnt", 64'(u_a.pend_cnt_q), 64'h0);

    // Instance B: MAX_PENDING=2 on slave 1
    cyc(); b_req(1, 4'h0);
    cyc();
    cyc(); #1;
    check("max_stall", 64'({b_mrdy, b_sav}), 64'h0);
    check("max_cnt2", 64'(u_b.pend_cnt_q), 64'h2);
    cyc(); b_srv = 3'b010; set_rd_b(1, 32'h99); #1;
    check("max_resp", 64'({b_mrv, b_mrdy}), 64'b10);
    cyc(); #1;
    check("max_both", 64'({b_mrv, b_mrdy}), 64'b11);
    cyc(); b_av = 1'b0; #1;
    check("max_cnt1", 64'(u_b.pend_cnt_q), 64'h1);
    cyc(); b_srv = 3'b000; #1;
    check("max_cnt0", 64'(u_b.pend_cnt_q), 64'h0);

    // Instance B: select 3 is unmapped with three slaves
    cyc(); b_req(3, 4'h0); #1;
`ifdef IOB_SPLIT_DECERR_EN
    check("decerr_acc", 64'({b_mrdy, b_sav}), 64'b1_000);
    cyc(); b_av = 1'b0; #1;
    check("decerr_rsp", 64'({b_mrv, b_mrd}), 64'h1_FFFF_FFFF);
    cyc(); #1;
    check("decerr_done", 64'({b_mrv, u_b.pend_cnt_q}), 64'h0);
`else
    check("unmap_rdy", 64'({b_mrdy, b_sav}), 64'h0);
    cyc(); b_av = 1'b0; #1;
    check("unmap_rv", 64'({b_mrv, u_b.pend_cnt_q}), 64'h0);
`endif

    cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
